// File: rtl/ifu_fetch_ctrl.sv
// ============================================================================
// Module   : ifu_fetch_ctrl
// Purpose  : IFU fetch controller: PC owner, 2-entry {pc, instr} queue to decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES  = 32,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter bit          WRAP_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        fetch_err
);

    localparam logic [32:0] C_IMEM_BYTES = 33'(IMEM_BYTES);
    localparam logic [3:0]  C_BOOT_LAST  = 4'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0][31:0]  ent_pc_q, ent_pc_d;
    logic [1:0][31:0]  ent_instr_q, ent_instr_d;
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;
    logic              halted_q, halted_d;
    logic              fetch_err_q, fetch_err_d;

    logic              w_pop;
    logic              w_push;
    logic              w_redir;
    logic              w_redir_legal;
    logic              w_tail;
    logic [32:0]       w_pc_plus4;

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pc_d        = pc_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        head_d      = head_q;
        count_d     = count_q;
        halted_d    = halted_q;
        fetch_err_d = fetch_err_q;

        w_pop         = (count_q != 2'd0) && id_ready;
        w_push        = (state_q == ST_FETCH) && !redirect_valid && (count_q != 2'd2);
        w_redir       = redirect_valid && (state_q != ST_BOOT) && !fetch_err_q;
        w_redir_legal = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < C_IMEM_BYTES);
        w_tail        = head_q ^ count_q[0];
        w_pc_plus4    = {1'b0, pc_q} + 33'd4;

        if (state_q == ST_BOOT) begin
            boot_cnt_d = boot_cnt_q + 4'd1;
            if (boot_cnt_q == C_BOOT_LAST) begin
                state_d = ST_FETCH;
            end
        end

        if (w_pop) begin
            head_d = ~head_q;
        end

        if (w_push) begin
            ent_pc_d[w_tail]    = pc_q;
            ent_instr_d[w_tail] = imem_instr;
            if (w_pc_plus4 < C_IMEM_BYTES) begin
                pc_d = w_pc_plus4[31:0];
            end else if (WRAP_EN) begin
                pc_d = 32'h0000_0000;
            end else begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
            end
        end

        count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};

        // Redirect wins over push; a same-cycle pop has already advanced the head.
        if (w_redir) begin
            count_d = 2'd0;
            if (w_redir_legal) begin
                pc_d     = redirect_pc;
                state_d  = ST_FETCH;
                halted_d = 1'b0;
            end else begin
                fetch_err_d = 1'b1;
                halted_d    = 1'b1;
                state_d     = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= 4'd0;
            pc_q        <= RESET_PC;
            ent_pc_q    <= '0;
            ent_instr_q <= '0;
            head_q      <= 1'b0;
            count_q     <= 2'd0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pc_q        <= pc_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
            head_q      <= head_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_pc   = pc_q;
    assign id_valid  = (count_q != 2'd0);
    assign id_instr  = ent_instr_q[head_q];
    assign id_pc     = ent_pc_q[head_q];
    assign halted    = halted_q;
    assign fetch_err = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
// ============================================================================
// Module   : tb_ifu_fetch_ctrl
// Purpose  : Directed table-driven bench for ifu_fetch_ctrl (wrap and halt variants)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic [31:0] imem_pc, imem_instr, id_instr, id_pc;
    logic        id_valid, halted, fetch_err;
    logic [31:0] nw_imem_pc, nw_imem_instr, nw_id_instr, nw_id_pc;
    logic        nw_id_valid, nw_halted, nw_fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'd0)      return 32'h0094_0333;
        else if (pc == 32'd4) return 32'h4139_03B3;
        else                  return 32'hA5A5_0000 | pc;
    endfunction

    assign imem_instr    = mem_word(imem_pc);
    assign nw_imem_instr = mem_word(nw_imem_pc);

    ifu_fetch_ctrl #(.WRAP_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .halted(halted), .fetch_err(fetch_err)
    );

    ifu_fetch_ctrl #(.WRAP_EN(1'b0)) dut_nw (
        .clk(clk), .reset_n(reset_n), .imem_pc(nw_imem_pc), .imem_instr(nw_imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(nw_id_valid), .id_ready(id_ready), .id_instr(nw_id_instr), .id_pc(nw_id_pc),
        .halted(nw_halted), .fetch_err(nw_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic        v;
        logic [31:0] pc;
        logic        chk_nw;
        logic        nv;
        logic [31:0] npc;
        logic        nh;
    } vec_t;

    vec_t tab [23];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Each row is the id_ready driven before rising edge N and the state expected after it.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            id_ready = tab[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("row%0d id_valid", i), {31'd0, id_valid}, {31'd0, tab[i].v});
            check($sformatf("row%0d halted", i), {31'd0, halted}, 32'd0);
            if (tab[i].v) begin
                check($sformatf("row%0d id_pc", i), id_pc, tab[i].pc);
                check($sformatf("row%0d id_instr", i), id_instr, mem_word(tab[i].pc));
            end
            if (tab[i].chk_nw) begin
                check($sformatf("row%0d nw id_valid", i), {31'd0, nw_id_valid}, {31'd0, tab[i].nv});
                check($sformatf("row%0d nw halted", i), {31'd0, nw_halted}, {31'd0, tab[i].nh});
                if (tab[i].nv) begin
                    check($sformatf("row%0d nw id_pc", i), nw_id_pc, tab[i].npc);
                end
            end
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Free-running fetch, ready high: wrap instance and halt-at-end instance side by side
        tab[0]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0};
        tab[1]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0};
        tab[2]  = '{1'b1, 1'b1, 32'd0,  1'b1, 1'b1, 32'd0,  1'b0};
        tab[3]  = '{1'b1, 1'b1, 32'd4,  1'b1, 1'b1, 32'd4,  1'b0};
        tab[4]  = '{1'b1, 1'b1, 32'd8,  1'b1, 1'b1, 32'd8,  1'b0};
        tab[5]  = '{1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 32'd12, 1'b0};
        tab[6]  = '{1'b1, 1'b1, 32'd16, 1'b1, 1'b1, 32'd16, 1'b0};
        tab[7]  = '{1'b1, 1'b1, 32'd20, 1'b1, 1'b1, 32'd20, 1'b0};
        tab[8]  = '{1'b1, 1'b1, 32'd24, 1'b1, 1'b1, 32'd24, 1'b0};
        tab[9]  = '{1'b1, 1'b1, 32'd28, 1'b1, 1'b1, 32'd28, 1'b1};
        tab[10] = '{1'b1, 1'b1, 32'd0,  1'b1, 1'b0, 32'd0,  1'b1};
        tab[11] = '{1'b1, 1'b1, 32'd4,  1'b1, 1'b0, 32'd0,  1'b1};
        // Back-pressure: ready low for five cycles after first valid, then released
        tab[12] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[13] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[14] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[15] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[16] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[17] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[18] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[19] = '{1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[20] = '{1'b1, 1'b1, 32'd4,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[21] = '{1'b1, 1'b1, 32'd8,  1'b0, 1'b0, 32'd0,  1'b0};
        tab[22] = '{1'b1, 1'b1, 32'd12, 1'b0, 1'b0, 32'd0,  1'b0};

        reset_n        = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #1;
        check("reset id_valid", {31'd0, id_valid}, 32'd0);
        check("reset id_pc", id_pc, 32'd0);
        check("reset id_instr", id_instr, 32'd0);
        check("reset halted", {31'd0, halted}, 32'd0);
        check("reset fetch_err", {31'd0, fetch_err}, 32'd0);
        check("reset imem_pc", imem_pc, 32'd0);

        apply_reset();
        run_rows(0, 11);

        apply_reset();
        run_rows(12, 22);

        // Fill the queue, then drop reset between edges
        step(1'b0, 1'b0, 32'd0);
        check("full id_valid", {31'd0, id_valid}, 32'd1);
        check("full id_pc", id_pc, 32'd12);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst id_valid", {31'd0, id_valid}, 32'd0);
        check("async rst id_pc", id_pc, 32'd0);
        check("async rst imem_pc", imem_pc, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_rows(0, 11);

        // Redirect to 16 while queue holds pc 4,8
        apply_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("pre-redir id_pc", id_pc, 32'd4);
        step(1'b0, 1'b1, 32'd16);
        check("flush id_valid", {31'd0, id_valid}, 32'd0);
        check("redir imem_pc", imem_pc, 32'd16);
        step(1'b1, 1'b0, 32'd0);
        check("post-redir id_valid", {31'd0, id_valid}, 32'd1);
        check("post-redir id_pc", id_pc, 32'd16);
        step(1'b1, 1'b0, 32'd0);
        check("post-redir2 id_pc", id_pc, 32'd20);
        check("post-redir2 id_instr", id_instr, 32'hA5A5_0014);
        // Redirect and pop together: queue ends empty
        step(1'b1, 1'b1, 32'd0);
        check("redir+pop id_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("redir0 id_pc", id_pc, 32'd0);
        check("redir0 id_instr", id_instr, 32'h0094_0333);

        // Misaligned target: sticky error, later redirect ignored
        step(1'b1, 1'b1, 32'd6);
        check("err fetch_err", {31'd0, fetch_err}, 32'd1);
        check("err halted", {31'd0, halted}, 32'd1);
        check("err id_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b1, 32'd8);
        step(1'b1, 1'b0, 32'd0);
        check("err ignore id_valid", {31'd0, id_valid}, 32'd0);
        check("err ignore fetch_err", {31'd0, fetch_err}, 32'd1);
        check("err ignore imem_pc", imem_pc, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check("err rst fetch_err", {31'd0, fetch_err}, 32'd0);
        check("err rst halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Upstream neighbour of the instruction memory inside the IFU.
- Owns the program counter and drives it onto the memory's PC input; the memory returns the 32-bit instruction combinationally.
- Captures each {pc, instruction} pair into a 2-entry queue and presents it to decode over a valid/ready handshake.
- Handles start-up delay, branch/jump redirect with flush, end-of-memory wrap or halt, and fetch-address errors.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 32, instruction memory size in bytes; a legal PC is < IMEM_BYTES and word-aligned.
- BOOT_CYCLES, 2, idle cycles after reset release before the first fetch, giving memory initialisation time to settle; legal range 1..15.
- WRAP_EN, 1, 1 = PC wraps to 0 after the last word; 0 = halt after the last word.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- imem_pc  output  32  PC to instruction memory; equals the internal PC register.
- imem_instr  input  32  instruction returned combinationally for imem_pc.
- redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
- redirect_pc  input  32  redirect target, sampled when redirect_valid=1.
- id_valid  output  1  queue head valid toward decode.
- id_ready  input  1  decode accepts the head when id_valid & id_ready.
- id_instr  output  32  instruction at queue head.
- id_pc  output  32  PC of id_instr.
- halted  output  1  fetch stopped (end of memory with WRAP_EN=0, or error).
- fetch_err  output  1  sticky: redirect target misaligned or >= IMEM_BYTES.

Behaviour:
- Reset (reset_n=0, async):
  - pc=RESET_PC; state=BOOT; boot counter=0; queue count=0.
  - Outputs: id_valid=0, id_instr=0, id_pc=0, halted=0, fetch_err=0.
  - Reset asserted mid-operation discards the queue and any in-flight redirect immediately.
- States: BOOT, FETCH, HALT.
- BOOT:
  - Boot counter increments each edge; moves to FETCH on the edge where the counter reaches BOOT_CYCLES-1.
  - No pushes in BOOT. Redirects in BOOT are ignored.
- FETCH, push rule:
  - Pushes when redirect_valid=0 and count<2. Push = {imem_pc, imem_instr} written at the tail.
  - A pop in the same cycle does not enable a push when count=2. Pop and push together at count=1 keeps count=1, so throughput is 1 instr/cycle while id_ready=1.
- Next-PC on push:
  - If pc+4 < IMEM_BYTES, pc=pc+4.
  - Else if WRAP_EN=1, pc=0.
  - Else pc is unchanged, state=HALT, halted=1.
- Latency: first id_valid=1 at the (BOOT_CYCLES+1)th rising edge after reset release, with id_pc=RESET_PC.
- Pop: on id_valid & id_ready the head is removed; id_valid/id_instr/id_pc reflect the new head after the edge. id_instr and id_pc hold stable while id_valid=1 and id_ready=0.
- Redirect (FETCH or HALT with fetch_err=0), target legal (redirect_pc[1:0]==0 and < IMEM_BYTES):
  - Flush queue (count=0, id_valid=0 next cycle; any pop that cycle is still honoured at decode).
  - pc=redirect_pc, no push that cycle, state=FETCH, halted=0.
  - First post-redirect instruction appears at the 2nd edge after the pulse.
- Redirect, target illegal:
  - Flush queue, fetch_err=1, halted=1, state=HALT; pc unchanged.
  - Only reset leaves this condition; later redirects are ignored.
- HALT without error: the queue still drains normally; no pushes.
- Simultaneous events:
  - Redirect has priority over push.
  - Redirect and pop in the same cycle: the pop completes for decode, and the queue ends empty.
- Queue ordering: strict FIFO; count range 0..2; never overflows.

Test Plan:
- Reset release, id_ready=1, defaults -> id_valid rises on edge 3; id_pc sequence 0,4,...,28,0,4 (wrap); id_instr at pc 0 = 32'h00940333, at 4 = 32'h413903B3.
- WRAP_EN=0, id_ready=1 -> eight instructions pc 0..28 delivered, halted=1 after the push of pc 28; id_valid=0 once drained.
- id_ready=0 from first valid for 5 cycles -> count saturates at 2, id_pc held at 0, then releasing ready delivers 0,4,8 with no gap or duplicate.
- redirect_valid pulse with redirect_pc=16 while queue holds pc 4,8 -> queue flushed, next delivered id_pc=16 two edges later, then 20.
- redirect_pc=6 -> fetch_err=1, halted=1, id_valid=0; a later redirect to 8 is ignored; asserting reset_n=0 clears both flags.
- reset_n asserted asynchronously mid-stream with the queue full -> id_valid drops without a clock edge; restart reproduces the first scenario exactly.
